uart_tx_generic: RTL

Parametrised UART transmitter, successor to the fixed 8N1 transmitter in the UART path. It serialises one data word per handshake into a start bit, DATA_BITS data bits, an optional parity bit and STOP_BITS stop bits. Each bit is held for SAMPLES_PER_BIT pulses of an external `sample_trigger`. It sits between the byte-source logic and the TX pin, driven by the shared sample-rate strobe generator.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_bit_timer.sv | 30 +++
 rtl/uart_tx_generic.sv | 132 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types (parity selection, TX states) and line-level constants.
package uart_pkg;
    typedef enum logic [1:0] {
        NONE = 2'b00,
        ODD  = 2'b01,
        EVEN = 2'b10
    } uart_parity_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } uart_tx_state_t;

    localparam logic UART_IDLE_LEVEL = 1'b1;
endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: counts sample_trigger pulses and flags the first and last sample of each bit.
// Ports: clk, rst (sync, active-high); clear restarts the count; enable gates counting;
// sample_trigger is the sample tick; first marks sample 0 of a bit; bit_done marks the
// final sample of a bit (one pulse every SAMPLES_PER_BIT counted ticks).
module uart_bit_timer #(
    parameter int SAMPLES_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    input  logic sample_trigger,
    output logic first,
    output logic bit_done
);
    localparam int CW = $clog2(SAMPLES_PER_BIT);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick;

    assign tick     = enable && sample_trigger;
    assign first    = tick && cnt_q == '0;
    assign bit_done = tick && cnt_q == CW'(SAMPLES_PER_BIT - 1);
    assign cnt_d    = clear ? '0 : !tick ? cnt_q : bit_done ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/uart_tx_generic.sv
// uart_tx_generic: parametrised UART transmitter (start, DATA_BITS data, optional parity, STOP_BITS stop).
// Ports: clk, rst (sync, active-high); sample_trigger sample tick; data/start accept a word when ready;
// parity_mode (00 none, 01 odd, 10 even, 11 none) exists only when UART_TX_PARITY_EN is defined;
// serial_data is the TX line (idles at 1); ready is high while idle and able to accept a word.
module uart_tx_generic
    import uart_pkg::*;
#(
    parameter int DATA_BITS       = 8,
    parameter int SAMPLES_PER_BIT = 16,
    parameter int STOP_BITS       = 1,
    parameter int LSB_FIRST       = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sample_trigger,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 start,
`ifdef UART_TX_PARITY_EN
    input  logic [1:0]           parity_mode,
`endif
    output logic                 serial_data,
    output logic                 ready
);
    localparam int BW = $clog2(DATA_BITS + 1);

    uart_tx_state_t       state_q, state_d;
    logic [DATA_BITS-1:0] sh_q, sh_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic                 serial_q, serial_d;
    logic                 ready_q;
    logic                 accept, first, bit_done, cur_bit, par_en, par_bit;

    assign accept      = start && ready_q;
    assign cur_bit     = LSB_FIRST != 0 ? sh_q[0] : sh_q[DATA_BITS-1];
    assign serial_data = serial_q;
    assign ready       = ready_q;

    uart_bit_timer #(.SAMPLES_PER_BIT(SAMPLES_PER_BIT)) u_timer (
        .clk            (clk),
        .rst            (rst),
        .clear          (accept),
        .enable         (state_q != S_IDLE),
        .sample_trigger (sample_trigger),
        .first          (first),
        .bit_done       (bit_done)
    );

`ifdef UART_TX_PARITY_EN
    logic [1:0] mode_q;
    logic       par_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= NONE;
            par_q  <= 1'b0;
        end else if (accept) begin
            mode_q <= parity_mode;
            par_q  <= ^data;
        end
    end

    assign par_en  = mode_q == ODD || mode_q == EVEN;
    assign par_bit = mode_q == EVEN ? par_q : ~par_q;
`else
    assign par_en  = 1'b0;
    assign par_bit = 1'b0;
`endif

    // Each bit's level is registered on its first counted sample; bit_done advances the FSM.
    always_comb begin
        state_d  = state_q;
        sh_d     = sh_q;
        bit_d    = bit_q;
        serial_d = serial_q;
        case (state_q)
            S_IDLE: begin
                serial_d = UART_IDLE_LEVEL;
                if (accept) begin
                    state_d = S_START;
                    sh_d    = data;
                    bit_d   = '0;
                end
            end
            S_START: begin
                if (first) serial_d = 1'b0;
                if (bit_done) state_d = S_DATA;
            end
            S_DATA: begin
                if (first) serial_d = cur_bit;
                if (bit_done) begin
                    sh_d  = LSB_FIRST != 0 ? sh_q >> 1 : sh_q << 1;
                    bit_d = bit_q + 1'b1;
                    if (bit_q == BW'(DATA_BITS - 1)) begin
                        bit_d   = '0;
                        state_d = par_en ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (first) serial_d = par_bit;
                if (bit_done) state_d = S_STOP;
            end
            S_STOP: begin
                if (first) serial_d = 1'b1;
                if (bit_done) begin
                    bit_d = bit_q + 1'b1;
                    if (bit_q == BW'(STOP_BITS - 1)) begin
                        bit_d   = '0;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            sh_q     <= '0;
            bit_q    <= '0;
            serial_q <= UART_IDLE_LEVEL;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sh_q     <= sh_d;
            bit_q    <= bit_d;
            serial_q <= serial_d;
            ready_q  <= state_d == S_IDLE;
        end
    end
endmodule
